// File: rtl/gsram_arb_pkg.sv
// Shared constants and types for the dual-port SRAM arbiter.
// Holds default sizes, the per-port tag type and idle port-drive values.
package gsram_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int ABITS_DEF = 11;
    localparam int DBITS_DEF = 8;

    // Wide enough for the largest supported requester count (8).
    localparam int IDXW = 3;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            rd;
    } port_tag_t;

    localparam port_tag_t TAG_IDLE = '0;
    localparam logic      IDLE_CE  = 1'b0;
    localparam logic      IDLE_WE  = 1'b0;

endpackage

// File: rtl/gsram_rr_pick2.sv
// Combinational two-winner round-robin picker.
// Ports: valid mask, ptr (start index), inhibit1; outputs g0/idx0, g1/idx1.
// idx1 is the port-1 candidate and never depends on inhibit1.
module gsram_rr_pick2 #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic            inhibit1,
    output logic            g0,
    output logic [PW-1:0]   idx0,
    output logic            g1,
    output logic [PW-1:0]   idx1
);

    logic found1;

    always_comb begin : pick
        int j;
        g0     = 1'b0;
        idx0   = '0;
        found1 = 1'b0;
        idx1   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (valid[j]) begin
                if (!g0) begin
                    g0   = 1'b1;
                    idx0 = PW'(j);
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = PW'(j);
                end
            end
        end
    end

    // Kept outside the search so the inhibit path cannot loop back.
    assign g1 = found1 & ~inhibit1;

endmodule

// File: rtl/gsram_2048x8_arbiter.sv
// NREQ-requester arbiter onto a dual-port 2048x8 SRAM, 1-cycle read return.
// Ports: CLK, RST (sync, active-high), req_* in, req_ready/rsp_* out,
// SRAM ports A/D/WE/CE/WEM out, Q in. Macro GSRAM_ARB_CONFLICT_EN holds
// back a same-address port-1 candidate when either access is a write.
module gsram_2048x8_arbiter
    import gsram_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int ABITS = ABITS_DEF,
    parameter int DBITS = DBITS_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*ABITS-1:0] req_addr,
    input  logic [NREQ*DBITS-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DBITS-1:0]      rsp_data,
    output logic [DBITS-1:0]      rsp_data1,
    output logic [NREQ-1:0]       rsp_lane,
    output logic [ABITS-1:0]      A0,
    output logic [DBITS-1:0]      D0,
    output logic                  WE0,
    output logic                  CE0,
    output logic [DBITS-1:0]      WEM0,
    input  logic [DBITS-1:0]      Q0,
    output logic [ABITS-1:0]      A1,
    output logic [DBITS-1:0]      D1,
    output logic                  WE1,
    output logic                  CE1,
    output logic [DBITS-1:0]      WEM1,
    input  logic [DBITS-1:0]      Q1
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [NREQ-1:0]  elig;
    logic             g0, g1, inhibit1;
    logic [PW-1:0]    idx0, idx1;
    logic [ABITS-1:0] a_c0, a_c1;
    logic             w_c0, w_c1;
    port_tag_t        tag0, tag1;

    // Nothing is granted while reset is held.
    assign elig = RST ? '0 : req_valid;

    gsram_rr_pick2 #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid    (elig),
        .ptr      (rr_ptr),
        .inhibit1 (inhibit1),
        .g0       (g0),
        .idx0     (idx0),
        .g1       (g1),
        .idx1     (idx1)
    );

    assign a_c0 = req_addr[int'(idx0)*ABITS +: ABITS];
    assign a_c1 = req_addr[int'(idx1)*ABITS +: ABITS];
    assign w_c0 = req_write[idx0];
    assign w_c1 = req_write[idx1];

`ifdef GSRAM_ARB_CONFLICT_EN
    assign inhibit1 = g0 && (a_c0 == a_c1) && (w_c0 || w_c1);
`else
    assign inhibit1 = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (g0) req_ready[idx0] = 1'b1;
        if (g1) req_ready[idx1] = 1'b1;
    end

    assign CE0  = g0 ? 1'b1 : IDLE_CE;
    assign WE0  = g0 ? w_c0 : IDLE_WE;
    assign A0   = g0 ? a_c0 : '0;
    assign D0   = g0 ? req_wdata[int'(idx0)*DBITS +: DBITS] : '0;
    assign WEM0 = '1;

    assign CE1  = g1 ? 1'b1 : IDLE_CE;
    assign WE1  = g1 ? w_c1 : IDLE_WE;
    assign A1   = g1 ? a_c1 : '0;
    assign D1   = g1 ? req_wdata[int'(idx1)*DBITS +: DBITS] : '0;
    assign WEM1 = '1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
            tag0   <= TAG_IDLE;
            tag1   <= TAG_IDLE;
        end else begin
            tag0 <= '{idx: IDXW'(idx0), rd: g0 & ~w_c0};
            tag1 <= '{idx: IDXW'(idx1), rd: g1 & ~w_c1};
            // Resume just past whichever grant came last in ring order.
            if (g1)
                rr_ptr <= PW'((int'(idx1) + 1) % NREQ);
            else if (g0)
                rr_ptr <= PW'((int'(idx0) + 1) % NREQ);
        end
    end

    // Read data is steered straight from the port Q; lane 1 is port 1.
    always_comb begin
        rsp_valid = '0;
        rsp_lane  = '0;
        rsp_data  = '0;
        rsp_data1 = '0;
        if (!RST) begin
            if (tag0.rd) rsp_data  = Q0;
            if (tag1.rd) rsp_data1 = Q1;
            for (int i = 0; i < NREQ; i++) begin
                if (tag0.rd && tag0.idx == IDXW'(i))
                    rsp_valid[i] = 1'b1;
                if (tag1.rd && tag1.idx == IDXW'(i)) begin
                    rsp_valid[i] = 1'b1;
                    rsp_lane[i]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gsram_2048x8_arbiter.sv
// Bench for gsram_2048x8_arbiter: vector table with expected grants,
// SRAM model on both ports, read-response scoreboard.
module tb_gsram_2048x8_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req_valid, req_write, req_ready;
    logic [43:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  rsp_valid, rsp_lane;
    logic [7:0]  rsp_data, rsp_data1;
    logic [10:0] A0, A1;
    logic [7:0]  D0, D1, WEM0, WEM1;
    logic        WE0, WE1, CE0, CE1;
    logic [7:0]  Q0 = '0;
    logic [7:0]  Q1 = '0;

    gsram_2048x8_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_data1(rsp_data1),
        .rsp_lane(rsp_lane),
        .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .WEM0(WEM0), .Q0(Q0),
        .A1(A1), .D1(D1), .WE1(WE1), .CE1(CE1), .WEM1(WEM1), .Q1(Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] initv(int i);
        return 8'(i * 7 + 3);
    endfunction

    logic [7:0] sram [2048];
    bit         inited = 1'b0;

    always @(posedge CLK) begin
        if (!inited) begin
            for (int i = 0; i < 2048; i++) sram[i] <= initv(i);
            inited <= 1'b1;
        end else begin
            if (CE0) begin
                if (WE0) sram[A0] <= D0;
                else     Q0 <= sram[A0];
            end
            if (CE1) begin
                if (WE1) sram[A1] <= D1;
                else     Q1 <= sram[A1];
            end
        end
    end

    typedef struct packed {
        logic            rst;
        logic [3:0]      v;
        logic [3:0]      w;
        logic [3:0][10:0] a;
        logic [3:0][7:0] d;
        logic [3:0]      rdy;
        logic            ce0;
        logic [1:0]      i0;
        logic            ce1;
        logic [1:0]      i1;
    } vec_t;

    typedef struct packed {
        logic [3:0] rv;
        logic [3:0] lane;
        logic [7:0] d0;
        logic [7:0] d1;
    } rsp_t;

    vec_t       tbl [$];
    rsp_t       sb  [$];
    logic [7:0] ref_mem [2048];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] v, w,
                       input logic [43:0] a, input logic [31:0] d,
                       input logic [3:0] rdy, input logic ce0,
                       input logic [1:0] i0, input logic ce1,
                       input logic [1:0] i1);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.a = a; t.d = d;
        t.rdy = rdy; t.ce0 = ce0; t.i0 = i0; t.ce1 = ce1; t.i1 = i1;
        tbl.push_back(t);
    endtask

    localparam logic [10:0] Z = 11'h0;

    initial begin
        RST = 1'b1; req_valid = '0; req_write = '0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = initv(i);

        // reset: no grants
        add(1, 4'b1111, 4'b0, '0, '0, 4'b0000, 0, 0, 0, 0);
        add(1, 4'b1111, 4'b0, '0, '0, 4'b0000, 0, 0, 0, 0);
        // single read, ptr 0 -> 1
        add(0, 4'b0001, 4'b0, {Z, Z, Z, 11'h010}, '0, 4'b0001, 1, 0, 0, 0);
        // ptr 1 -> r3 wins, ptr -> 0
        add(0, 4'b1000, 4'b0, {11'h7FE, Z, Z, Z}, '0, 4'b1000, 1, 3, 0, 0);
        // all four reading: (0,1) (2,3) (0,1) (2,3)
        for (int k = 0; k < 2; k++) begin
            add(0, 4'b1111, 4'b0, {11'h004, 11'h003, 11'h002, 11'h001}, '0,
                4'b0011, 1, 0, 1, 1);
            add(0, 4'b1111, 4'b0, {11'h004, 11'h003, 11'h002, 11'h001}, '0,
                4'b1100, 1, 2, 1, 3);
        end
        // write A5 @7FF by r2 (ptr 0 -> 3), read back by r1 (ptr -> 2)
        add(0, 4'b0100, 4'b0100, {Z, 11'h7FF, Z, Z}, {8'h0, 8'hA5, 16'h0},
            4'b0100, 1, 2, 0, 0);
        add(0, 4'b0010, 4'b0, {Z, Z, 11'h7FF, Z}, '0, 4'b0010, 1, 1, 0, 0);
        // dual write 3C@000 (r2) and C3@400 (r3), ptr -> 0
        add(0, 4'b1100, 4'b1100, {11'h400, 11'h000, Z, Z},
            {8'hC3, 8'h3C, 16'h0}, 4'b1100, 1, 2, 1, 3);
        // dual read back, ptr -> 2
        add(0, 4'b0011, 4'b0, {Z, Z, 11'h400, 11'h000}, '0,
            4'b0011, 1, 0, 1, 1);
        // r0 and r1 both write 0x123
`ifdef GSRAM_ARB_CONFLICT_EN
        add(0, 4'b0011, 4'b0011, {Z, Z, 11'h123, 11'h123},
            {16'h0, 8'h22, 8'h11}, 4'b0001, 1, 0, 0, 0);
`else
        add(0, 4'b0011, 4'b0011, {Z, Z, 11'h123, 11'h123},
            {16'h0, 8'h22, 8'h11}, 4'b0011, 1, 0, 1, 1);
`endif
        add(0, 4'b0010, 4'b0010, {Z, Z, 11'h123, Z}, {16'h0, 8'h22, 8'h0},
            4'b0010, 1, 1, 0, 0);
        // read 0x123 by r3, ptr 2 -> 0
        add(0, 4'b1000, 4'b0, {11'h123, Z, Z, Z}, '0, 4'b1000, 1, 3, 0, 0);
        // read by r2, then reset the next cycle: no response
        add(0, 4'b0100, 4'b0, {Z, 11'h050, Z, Z}, '0, 4'b0100, 1, 2, 0, 0);
        add(1, 4'b0001, 4'b0, {Z, Z, Z, 11'h060}, '0, 4'b0000, 0, 0, 0, 0);
        // after release r0 wins first
        add(0, 4'b1001, 4'b0, {11'h061, Z, Z, 11'h060}, '0,
            4'b1001, 1, 0, 1, 3);
        // write on port 0 with read on port 1, ptr -> 3
        add(0, 4'b0110, 4'b0010, {Z, 11'h301, 11'h300, Z},
            {16'h0, 8'h66, 8'h0}, 4'b0110, 1, 1, 1, 2);
        add(0, 4'b0000, 4'b0, '0, '0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0, '0, '0, 4'b0000, 0, 0, 0, 0);

        sb.push_back('0);
        for (int n = 0; n < tbl.size(); n++) begin
            vec_t t;
            rsp_t e, ne;
            t = tbl[n];
            @(negedge CLK);
            RST = t.rst; req_valid = t.v; req_write = t.w;
            req_addr = t.a; req_wdata = t.d;
            #1;
            e = sb.pop_front();
            if (t.rst) e = '0;
            chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(e.rv));
            chk($sformatf("v%0d rsp_lane", n), 32'(rsp_lane), 32'(e.lane));
            if ((e.rv & ~e.lane) != 0 || t.rst)
                chk($sformatf("v%0d rsp_data", n), 32'(rsp_data), 32'(e.d0));
            if ((e.rv & e.lane) != 0 || t.rst)
                chk($sformatf("v%0d rsp_data1", n), 32'(rsp_data1), 32'(e.d1));
            chk($sformatf("v%0d ready", n), 32'(req_ready), 32'(t.rdy));
            chk($sformatf("v%0d ce0", n), 32'(CE0), 32'(t.ce0));
            chk($sformatf("v%0d ce1", n), 32'(CE1), 32'(t.ce1));
            chk($sformatf("v%0d we0", n), 32'(WE0), 32'(t.ce0 & t.w[t.i0]));
            chk($sformatf("v%0d we1", n), 32'(WE1), 32'(t.ce1 & t.w[t.i1]));
            chk($sformatf("v%0d a0", n), 32'(A0),
                32'(t.ce0 ? t.a[t.i0] : 11'h0));
            chk($sformatf("v%0d a1", n), 32'(A1),
                32'(t.ce1 ? t.a[t.i1] : 11'h0));
            chk($sformatf("v%0d d0", n), 32'(D0),
                32'(t.ce0 ? t.d[t.i0] : 8'h0));
            chk($sformatf("v%0d d1", n), 32'(D1),
                32'(t.ce1 ? t.d[t.i1] : 8'h0));
            ne = '0;
            if (t.ce0 && !t.w[t.i0]) begin
                ne.rv[t.i0] = 1'b1;
                ne.d0 = ref_mem[t.a[t.i0]];
            end
            if (t.ce1 && !t.w[t.i1]) begin
                ne.rv[t.i1]   = 1'b1;
                ne.lane[t.i1] = 1'b1;
                ne.d1 = ref_mem[t.a[t.i1]];
            end
            sb.push_back(ne);
            if (t.ce0 && t.w[t.i0]) ref_mem[t.a[t.i0]] = t.d[t.i0];
            if (t.ce1 && t.w[t.i1]) ref_mem[t.a[t.i1]] = t.d[t.i1];
        end

        // rr_ptr is 3 here; reset must bring it back to 0
        @(negedge CLK);
        RST = 1'b1; req_valid = 4'b1111; req_write = '0;
        #1;
        chk("hold ready", 32'(req_ready), 32'h0);
        chk("hold ce", 32'({CE0, CE1, WE0, WE1}), 32'h0);
        chk("hold rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge CLK);
        RST = 1'b0; req_valid = 4'b1010;
        req_addr = {11'h333, Z, 11'h111, Z};
        #1;
        chk("rel ready", 32'(req_ready), 32'hA);
        chk("rel a0", 32'(A0), 32'h111);
        chk("rel a1", 32'(A1), 32'h333);
        @(negedge CLK);
        req_valid = '0;
        #1;
        chk("rel rsp_valid", 32'(rsp_valid), 32'hA);
        chk("rel rsp_lane", 32'(rsp_lane), 32'h8);
        chk("rel rsp_data", 32'(rsp_data), 32'(ref_mem[11'h111]));
        chk("rel rsp_data1", 32'(rsp_data1), 32'(ref_mem[11'h333]));
        @(negedge CLK);
        #1;
        chk("rel pulse", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
